// File: rtl/pixel_sink.sv
// pixel_sink: consumer end of an 8-bit pixel valid/ready stream.
//
// It drives programmable backpressure and captures one frame per start.
// It reports the pixel count, a 16-bit checksum, an XOR signature, the
// min/max pixel, the next expected col/row, handshake-protocol errors and
// a stall timeout.
//
// Handshake: a pixel moves on a rising clk_out edge when valid_in and
// ready_in are both high. Once the source raises valid_in it must hold
// valid_in and pixel_in stable until that transfer happens. ready_in is a
// decode of registered state and bp_mode only; it never depends on
// valid_in.
//
// Ports
//   clk_out, rstn       clock, asynchronous active-low reset
//   pixel_in, valid_in  stream input
//   ready_in            stream backpressure (0 outside RUN)
//   start               arm one frame capture (honoured in IDLE only)
//   bp_mode             00 always, 01 alternate, 10 LFSR, 11 never ready
//   busy                high while in RUN
//   done                1-cycle pulse at frame end or timeout
//   pix_count, checksum, xor_sig, min_pix, max_pix   frame statistics
//   col, row            position of the next expected pixel
//   proto_err, timeout  sticky flags, cleared by start or reset
//   state_dbg           current FSM state (0 IDLE, 1 RUN, 2 DONE)
module pixel_sink #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk_out,
    input  logic        rstn,
    input  logic [7:0]  pixel_in,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic        start,
    input  logic [1:0]  bp_mode,
    output logic        busy,
    output logic        done,
    output logic [15:0] pix_count,
    output logic [15:0] checksum,
    output logic [7:0]  xor_sig,
    output logic [7:0]  min_pix,
    output logic [7:0]  max_pix,
    output logic [15:0] col,
    output logic [15:0] row,
    output logic        proto_err,
    output logic        timeout,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int              SW          = $clog2(TIMEOUT + 1);
    localparam logic [15:0]     FRAME_LEN   = 16'(IMG_W * IMG_H);
    localparam logic [15:0]     COL_LAST    = 16'(IMG_W - 1);
    localparam logic [SW-1:0]   STALL_LIMIT = SW'(TIMEOUT);

    state_t         state_q;
    logic [15:0]    pix_count_q, checksum_q, col_q, row_q;
    logic [7:0]     xor_sig_q, min_pix_q, max_pix_q;
    logic           proto_err_q, timeout_q;
    logic [SW-1:0]  stall_q;
    logic [7:0]     lfsr_q;
    logic           alt_q;
    logic           prev_valid_q, prev_ready_q;
    logic [7:0]     prev_pix_q;

    logic           ready_c;
    logic           xfer;
    logic [7:0]     lfsr_d;
    logic [15:0]    pix_count_d;
    logic [SW-1:0]  stall_d;
    logic           stall_violation;

    // Backpressure is a pure decode of the registered state.
    always_comb begin
        ready_c = 1'b0;
        if (state_q == S_RUN) begin
            case (bp_mode)
                2'b00:   ready_c = 1'b1;
                2'b01:   ready_c = alt_q;
                2'b10:   ready_c = lfsr_q[0];
                default: ready_c = 1'b0;
            endcase
        end
    end

    assign xfer        = valid_in & ready_c;
    // Fibonacci LFSR, taps 8,6,5,4: shift left and feed bits 7^5^4^3 into bit 0.
    assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign pix_count_d = pix_count_q + 16'd1;
    assign stall_d     = stall_q + 1'b1;
    // The source offered a pixel last cycle and was stalled. It must still
    // offer the same pixel this cycle.
    assign stall_violation = prev_valid_q & ~prev_ready_q &
                             (~valid_in | (pixel_in != prev_pix_q));

    always_ff @(posedge clk_out or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            pix_count_q  <= '0;
            checksum_q   <= '0;
            xor_sig_q    <= '0;
            min_pix_q    <= 8'hFF;
            max_pix_q    <= 8'h00;
            col_q        <= '0;
            row_q        <= '0;
            proto_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            stall_q      <= '0;
            lfsr_q       <= 8'hA5;
            alt_q        <= 1'b1;
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b0;
            prev_pix_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    prev_valid_q <= 1'b0;
                    if (start) begin
                        pix_count_q <= '0;
                        checksum_q  <= '0;
                        xor_sig_q   <= '0;
                        min_pix_q   <= 8'hFF;
                        max_pix_q   <= 8'h00;
                        col_q       <= '0;
                        row_q       <= '0;
                        proto_err_q <= 1'b0;
                        timeout_q   <= 1'b0;
                        stall_q     <= '0;
                        lfsr_q      <= 8'hA5;
                        alt_q       <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    alt_q        <= ~alt_q;
                    lfsr_q       <= lfsr_d;
                    prev_valid_q <= valid_in;
                    prev_ready_q <= ready_c;
                    prev_pix_q   <= pixel_in;
                    if (stall_violation) begin
                        proto_err_q <= 1'b1;
                    end
                    if (xfer) begin
                        pix_count_q <= pix_count_d;
                        checksum_q  <= checksum_q + {8'd0, pixel_in};
                        xor_sig_q   <= xor_sig_q ^ pixel_in;
                        if (pixel_in < min_pix_q) min_pix_q <= pixel_in;
                        if (pixel_in > max_pix_q) max_pix_q <= pixel_in;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 16'd1;
                        end else begin
                            col_q <= col_q + 16'd1;
                        end
                        stall_q <= '0;
                        if (pix_count_d == FRAME_LEN) state_q <= S_DONE;
                    end else begin
                        stall_q <= stall_d;
                        if (stall_d == STALL_LIMIT) begin
                            timeout_q <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    prev_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_in  = ready_c;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pix_count = pix_count_q;
    assign checksum  = checksum_q;
    assign xor_sig   = xor_sig_q;
    assign min_pix   = min_pix_q;
    assign max_pix   = max_pix_q;
    assign col       = col_q;
    assign row       = row_q;
    assign proto_err = proto_err_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pixel_sink.sv
module tb_pixel_sink;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 8;
    localparam int TIMEOUT = 1024;

    // ---------------- clock / reset ----------------
    logic        clk_out = 1'b0;
    logic        rstn    = 1'b0;
    always #5 clk_out = ~clk_out;

    logic [7:0]  pixel_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic        start    = 1'b0;
    logic [1:0]  bp_mode  = 2'b00;
    logic        busy, done, proto_err, timeout;
    logic [15:0] pix_count, checksum, col, row;
    logic [7:0]  xor_sig, min_pix, max_pix;
    logic [1:0]  state_dbg;

    pixel_sink #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT(TIMEOUT)) dut (
        .clk_out   (clk_out),
        .rstn      (rstn),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .start     (start),
        .bp_mode   (bp_mode),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count),
        .checksum  (checksum),
        .xor_sig   (xor_sig),
        .min_pix   (min_pix),
        .max_pix   (max_pix),
        .col       (col),
        .row       (row),
        .proto_err (proto_err),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] runs;   // expected RUN cycles, 16'hFFFF = not predicted
        logic [15:0] count;
        logic [15:0] sum;
        logic [7:0]  xs;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [15:0] col;
        logic [15:0] row;
        logic        proto;
        logic        tmo;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    logic [7:0]   frame_pix[$];
    logic [1:0]   cur_mode = 2'b00;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ready pattern: k is the RUN cycle index within the frame.
    function automatic logic model_ready(input logic [1:0] mode, input int k);
        logic [7:0] l;
        case (mode)
            2'b00: return 1'b1;
            2'b01: return (k % 2) == 0;
            2'b10: begin
                l = 8'hA5;
                for (int i = 0; i < k; i++) l = {l[6:0], ^(l & 8'hB8)};
                return l[0];
            end
            default: return 1'b0;
        endcase
    endfunction

    // Frame statistics straight from the list of pixels that will be accepted.
    task automatic push_expected(input int runs, input logic proto, input logic tmo);
        exp_t       e;
        int         s;
        logic [7:0] x, mn, mx;
        int         n;
        s = 0; x = 8'h00; mn = 8'hFF; mx = 8'h00;
        n = frame_pix.size();
        foreach (frame_pix[i]) begin
            s  = s + int'(frame_pix[i]);
            x  = x ^ frame_pix[i];
            if (frame_pix[i] < mn) mn = frame_pix[i];
            if (frame_pix[i] > mx) mx = frame_pix[i];
        end
        e.runs  = 16'(runs);
        e.count = 16'(n);
        e.sum   = 16'(s % 65536);
        e.xs    = x;
        e.mn    = mn;
        e.mx    = mx;
        e.col   = 16'(n % IMG_W);
        e.row   = 16'(n / IMG_W);
        e.proto = proto;
        e.tmo   = tmo;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int   k;
        exp_t e;
        k = 0;
        forever begin
            @(negedge clk_out);
            #2;
            if (!rstn) begin
                k = 0;
            end else if (busy) begin
                chk("ready_model", 32'(ready_in), 32'(model_ready(cur_mode, k)));
                k++;
            end else begin
                chk("ready_idle", 32'(ready_in), 0);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_count", 32'(pix_count), 32'(e.count));
                        chk("checksum",  32'(checksum),  32'(e.sum));
                        chk("xor_sig",   32'(xor_sig),   32'(e.xs));
                        chk("min_pix",   32'(min_pix),   32'(e.mn));
                        chk("max_pix",   32'(max_pix),   32'(e.mx));
                        chk("col",       32'(col),       32'(e.col));
                        chk("row",       32'(row),       32'(e.row));
                        chk("proto_err", 32'(proto_err), 32'(e.proto));
                        chk("timeout",   32'(timeout),   32'(e.tmo));
                        if (e.runs != 16'hFFFF) chk("run_cycles", 32'(k), 32'(e.runs));
                    end
                end
                k = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset(input string tag);
        chk({tag, "_ready"},  32'(ready_in),  0);
        chk({tag, "_busy"},   32'(busy),      0);
        chk({tag, "_done"},   32'(done),      0);
        chk({tag, "_count"},  32'(pix_count), 0);
        chk({tag, "_sum"},    32'(checksum),  0);
        chk({tag, "_xor"},    32'(xor_sig),   0);
        chk({tag, "_min"},    32'(min_pix),   'hFF);
        chk({tag, "_max"},    32'(max_pix),   0);
        chk({tag, "_col"},    32'(col),       0);
        chk({tag, "_row"},    32'(row),       0);
        chk({tag, "_proto"},  32'(proto_err), 0);
        chk({tag, "_tmo"},    32'(timeout),   0);
        chk({tag, "_state"},  32'(state_dbg), 0);
    endtask

    // Called and returns just after a falling edge.
    task automatic do_start(input logic [1:0] m);
        @(negedge clk_out);
        bp_mode  = m;
        cur_mode = m;
        start    = 1'b1;
        @(negedge clk_out);
        start    = 1'b0;
    endtask

    // Offer one pixel and hold it until accepted; optional idle gap afterwards.
    task automatic send_pixel(input logic [7:0] p, input bit gaps);
        int guard;
        guard    = 0;
        valid_in = 1'b1;
        pixel_in = p;
        #1;
        while (!ready_in && guard < 2000) begin
            @(negedge clk_out);
            #1;
            guard++;
        end
        if (!ready_in) chk("accept_bound", 32'(ready_in), 1);
        @(negedge clk_out);
        if (gaps) begin
            valid_in = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk_out);
        end
    endtask

    task automatic wait_idle(input int limit);
        int g;
        g = 0;
        while (busy && g < limit) begin
            @(negedge clk_out);
            g++;
        end
        if (busy) chk("frame_end_bound", 32'(busy), 0);
        repeat (3) @(negedge clk_out);
    endtask

    task automatic run_stream(input logic [1:0] m, input bit gaps, input bit pulse_start);
        do_start(m);
        foreach (frame_pix[i]) begin
            if (pulse_start && i == 20) start = 1'b1;
            send_pixel(frame_pix[i], gaps);
            start = 1'b0;
        end
        valid_in = 1'b0;
        wait_idle(300);
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        repeat (3) @(negedge clk_out);
        check_reset("por");
        rstn = 1'b1;
        repeat (2) @(negedge clk_out);

        // Always ready, back-to-back stream 0..63.
        frame_pix.delete();
        for (int i = 0; i < IMG_W * IMG_H; i++) frame_pix.push_back(8'(i));
        push_expected(IMG_W * IMG_H, 1'b0, 1'b0);
        run_stream(2'b00, 1'b0, 1'b0);

        // Alternate ready with valid held: 127 RUN cycles.
        push_expected(2 * IMG_W * IMG_H - 1, 1'b0, 1'b0);
        run_stream(2'b01, 1'b0, 1'b0);

        // LFSR backpressure, stream 255-i, random source gaps.
        frame_pix.delete();
        for (int i = 0; i < IMG_W * IMG_H; i++) frame_pix.push_back(8'(255 - i));
        push_expected(16'hFFFF, 1'b0, 1'b0);
        run_stream(2'b10, 1'b1, 1'b0);

        // Never ready: data change while stalled, then stall until timeout.
        frame_pix.delete();
        push_expected(TIMEOUT, 1'b1, 1'b1);
        do_start(2'b11);
        valid_in = 1'b1;
        pixel_in = 8'd5;
        @(negedge clk_out);
        pixel_in = 8'd6;
        @(negedge clk_out);
        #1;
        chk("proto_set", 32'(proto_err), 1);
        chk("proto_no_count", 32'(pix_count), 0);
        valid_in = 1'b0;
        repeat (50) @(negedge clk_out);
        chk("proto_sticky", 32'(proto_err), 1);
        wait_idle(1200);

        // Always ready but the source stays silent: timeout.
        push_expected(TIMEOUT, 1'b0, 1'b1);
        do_start(2'b00);
        wait_idle(1200);
        chk("timeout_idle_busy", 32'(busy), 0);

        // Reset in the middle of a frame after 10 transfers.
        frame_pix.delete();
        for (int i = 0; i < 10; i++) frame_pix.push_back(8'($urandom_range(0, 255)));
        do_start(2'b00);
        foreach (frame_pix[i]) send_pixel(frame_pix[i], 1'b0);
        chk("pre_reset_count", 32'(pix_count), 10);
        rstn = 1'b0;
        #1;
        check_reset("mid_reset");
        valid_in = 1'b0;
        @(negedge clk_out);
        rstn = 1'b1;
        repeat (2) @(negedge clk_out);
        frame_pix.delete();
        for (int i = 0; i < IMG_W * IMG_H; i++) frame_pix.push_back(8'(i));
        push_expected(IMG_W * IMG_H, 1'b0, 1'b0);
        run_stream(2'b00, 1'b0, 1'b0);

        // Random frames, random modes and gaps; start pulsed mid-frame is ignored.
        for (int f = 0; f < 4; f++) begin
            frame_pix.delete();
            for (int i = 0; i < IMG_W * IMG_H; i++) frame_pix.push_back(8'($urandom_range(0, 255)));
            push_expected(16'hFFFF, 1'b0, 1'b0);
            run_stream(2'($urandom_range(0, 2)), 1'b1, (f % 2) == 1);
        end

        repeat (5) @(negedge clk_out);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
